// File: rtl/spike_pattern_decoder.sv
// Windowed spike-onset counter with threshold readout and valid/ready result port.
// Optional argmax stage: define SPIKE_DECODER_WINNER_EN to build COMPARE and the winner register.
module spike_pattern_decoder #(
  parameter int N             = 7,
  parameter int WINDOW_CYCLES = 1024,
  parameter int CNT_W         = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     spikes,
  input  logic             start,
  input  logic [CNT_W-1:0] threshold,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     pattern_out,
  output logic             any_spike,
  output logic [2:0]       winner
);

  localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COUNT   = 2'd1,
    S_COMPARE = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

`ifdef SPIKE_DECODER_WINNER_EN
  localparam state_t AFTER_COUNT = S_COMPARE;
`else
  localparam state_t AFTER_COUNT = S_HOLD;
`endif

  state_t             state_r;
  state_t             state_s;
  logic [CNT_W-1:0]   cnt_r [N];
  logic [N-1:0]       prev_r;
  logic [N-1:0]       onset_s;
  logic [WIN_W-1:0]   win_cnt_r;
  logic               win_last_s;
  logic [CNT_W-1:0]   thr_r;
  logic [N-1:0]       pattern_s;
  logic               any_s;
  logic               busy_r;
  logic               out_valid_r;
  logic [N-1:0]       pattern_r;
  logic               any_r;

  assign onset_s    = spikes & ~prev_r;
  assign win_last_s = (win_cnt_r == WIN_W'(WINDOW_CYCLES - 1));

`ifdef SPIKE_DECODER_WINNER_EN
  logic [2:0]         scan_idx_r;
  logic               scan_last_s;
  logic [CNT_W-1:0]   max_r;
  logic [2:0]         best_r;
  logic [2:0]         winner_r;

  assign scan_last_s = (scan_idx_r == 3'(N - 1));
  assign winner      = winner_r;
`else
  assign winner      = 3'd0;
`endif

  assign busy        = busy_r;
  assign out_valid   = out_valid_r;
  assign pattern_out = pattern_r;
  assign any_spike   = any_r;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_s = S_COUNT;
        else       state_s = S_IDLE;
      end
      S_COUNT: begin
        if (win_last_s) state_s = AFTER_COUNT;
        else            state_s = S_COUNT;
      end
`ifdef SPIKE_DECODER_WINNER_EN
      S_COMPARE: begin
        if (scan_last_s) state_s = S_HOLD;
        else             state_s = S_COMPARE;
      end
`endif
      S_HOLD: begin
        if (out_valid_r && out_ready) state_s = S_IDLE;
        else                          state_s = S_HOLD;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Threshold compare and activity reduction over the final counts
  always_comb begin
    pattern_s = '0;
    any_s     = 1'b0;
    for (int i = 0; i < N; i++) begin
      pattern_s[i] = (cnt_r[i] >= thr_r);
      if (cnt_r[i] != '0) any_s = 1'b1;
      else                any_s = any_s;
    end
  end

  // Onset counters, edge-detect history and window timer
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_r    <= '0;
      win_cnt_r <= '0;
      thr_r     <= '0;
      for (int i = 0; i < N; i++) cnt_r[i] <= '0;
    end else if (state_r == S_IDLE && start) begin
      prev_r    <= '0;
      win_cnt_r <= '0;
      thr_r     <= threshold;
      for (int i = 0; i < N; i++) cnt_r[i] <= '0;
    end else if (state_r == S_COUNT) begin
      prev_r    <= spikes;
      win_cnt_r <= win_cnt_r + WIN_W'(1);
      // saturate rather than wrap so a hyperactive neuron never reads as silent
      for (int i = 0; i < N; i++) begin
        if (onset_s[i] && cnt_r[i] != CNT_MAX) cnt_r[i] <= cnt_r[i] + CNT_W'(1);
      end
    end
  end

`ifdef SPIKE_DECODER_WINNER_EN
  // Sequential argmax; strict greater-than keeps the lowest index on ties
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_idx_r <= 3'd0;
      max_r      <= '0;
      best_r     <= 3'd0;
    end else if (state_r == S_IDLE && start) begin
      scan_idx_r <= 3'd0;
      max_r      <= '0;
      best_r     <= 3'd0;
    end else if (state_r == S_COMPARE) begin
      scan_idx_r <= scan_idx_r + 3'd1;
      if (cnt_r[scan_idx_r] > max_r) begin
        max_r  <= cnt_r[scan_idx_r];
        best_r <= scan_idx_r;
      end
    end
  end
`endif

  // Result registers: published on the first HOLD cycle, cleared by handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      pattern_r   <= '0;
      any_r       <= 1'b0;
`ifdef SPIKE_DECODER_WINNER_EN
      winner_r    <= 3'd0;
`endif
    end else begin
      busy_r <= (state_s != S_IDLE);
      if (state_r == S_HOLD && !out_valid_r) begin
        out_valid_r <= 1'b1;
        pattern_r   <= pattern_s;
        any_r       <= any_s;
`ifdef SPIKE_DECODER_WINNER_EN
        winner_r    <= best_r;
`endif
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

endmodule
